// File: rtl/pc_fetch_unit.sv
// PC owner and instruction fetch sequencer for the RV32I core: fetches one word,
// exposes it for a single execute slot, then steps the PC from the controller's selection.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        instr_valid,
  output logic        misaligned,
  output logic        fetch_err,
  output logic [31:0] bad_addr,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_TRAP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_next_state;
  logic [31:0] r_pc, r_instr, r_bad, r_instret;
  logic [7:0]  r_cnt;
  logic        r_mis, r_ferr;
  logic [31:0] w_pc4, w_target;
  logic        w_misal, w_timeout;

  assign w_pc4     = r_pc + 32'd4;
  assign w_misal   = |w_target[1:0];
  assign w_timeout = (r_cnt == CNT_LAST);

  // JALR clears bit 0 only; bit 1 survives so a bad target still traps.
  always_comb begin
    w_target = w_pc4;
    case (PCSrc)
      2'b01:   w_target = r_pc + ImmExt;
      2'b10:   w_target = {ALUResult[31:1], 1'b0};
      default: w_target = w_pc4;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    case (r_state)
      S_IDLE:  w_next_state = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready)     w_next_state = S_EXEC;
        else if (w_timeout) w_next_state = S_TRAP;
      end
      S_EXEC: begin
        instr_valid  = 1'b1;
        w_next_state = w_misal ? S_TRAP : S_FETCH;
      end
      default: w_next_state = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc      <= RESET_PC;
      r_instr   <= NOP;
      r_cnt     <= 8'd0;
      r_mis     <= 1'b0;
      r_ferr    <= 1'b0;
      r_bad     <= 32'd0;
      r_instret <= 32'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            r_instr <= imem_rdata;
            r_cnt   <= 8'd0;
          end else if (w_timeout) begin
            r_ferr <= 1'b1;
            r_bad  <= r_pc;
            r_cnt  <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_EXEC: begin
          // Instr only carries a real word during the execute slot.
          r_instr <= NOP;
          if (w_misal) begin
            r_mis <= 1'b1;
            r_bad <= w_target;
          end else begin
            r_pc      <= w_target;
            r_instret <= r_instret + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = r_pc;
  assign PC         = r_pc;
  assign PCPlus4    = w_pc4;
  assign Instr      = r_instr;
  assign misaligned = r_mis;
  assign fetch_err  = r_ferr;
  assign bad_addr   = r_bad;
  assign instret    = r_instret;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboarded bench for pc_fetch_unit: a driver plays instruction memory and controller,
// a negedge monitor checks every execute slot against expectations from a PC/instret model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TO     = 16;
  localparam logic [31:0] NOPI   = 32'h0000_0013;

  logic        clk = 1'b0, reset = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] ImmExt = '0, ALUResult = '0, imem_rdata = '0;
  logic        imem_ready = 1'b0;
  logic        imem_req, instr_valid, misaligned, fetch_err;
  logic [31:0] imem_addr, Instr, PC, PCPlus4, bad_addr, instret;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TO), .NOP(NOPI)) dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .ImmExt(ImmExt), .ALUResult(ALUResult),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
    .instr_valid(instr_valid), .misaligned(misaligned), .fetch_err(fetch_err),
    .bad_addr(bad_addr), .instret(instret)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          tests = 0, fails = 0;
  logic [31:0] m_pc, m_ret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every execute slot must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && instr_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_slot: got slot at PC %h expected none", PC);
      end else begin
        mon_e = q.pop_front();
        chk("slot_instr", Instr, mon_e.instr);
        chk("slot_pc", PC, mon_e.pc);
        chk("slot_pcplus4", PCPlus4, mon_e.pc + 32'd4);
        chk("slot_instret", instret, mon_e.cnt);
      end
    end
  end

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [1:0] src,
                                             input logic [31:0] imm, input logic [31:0] alu);
    case (src)
      2'b01:   return pc + imm;
      2'b10:   return alu & 32'hFFFF_FFFE;
      default: return pc + 32'd4;
    endcase
  endfunction

  task automatic wait_req(output bit ok, output int waited);
    waited = 0;
    while (!imem_req && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    ok = imem_req;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL req_timeout: got no imem_req expected request within 40 cycles");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    imem_ready = 1'b0;
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", Instr, NOPI);
    chk("rst_pc", PC, RST_PC);
    chk("rst_pcplus4", PCPlus4, RST_PC + 32'd4);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
    chk("rst_ferr", {31'd0, fetch_err}, 32'd0);
    chk("rst_bad", bad_addr, 32'd0);
    chk("rst_instret", instret, 32'd0);
    q.delete();
    m_pc  = RST_PC;
    m_ret = 32'd0;
    reset = 1'b1;
  endtask

  task automatic trap_quiet(input string name);
    imem_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk({name, "_req"}, {31'd0, imem_req}, 32'd0);
      chk({name, "_valid"}, {31'd0, instr_valid}, 32'd0);
    end
    imem_ready = 1'b0;
  endtask

  task automatic xact(input int dly, input logic [31:0] rd, input logic [1:0] src,
                      input logic [31:0] imm, input logic [31:0] alu, input bit b2b);
    int          w;
    bit          ok;
    logic [31:0] nxt;
    wait_req(ok, w);
    if (!ok) return;
    if (b2b) chk("back_to_back", 32'(w), 32'd0);
    chk("imem_addr", imem_addr, m_pc);
    repeat (dly) begin
      imem_ready = 1'b0;
      @(negedge clk);
      chk("req_held", {31'd0, imem_req}, 32'd1);
    end
    imem_ready = 1'b1;
    imem_rdata = rd;
    PCSrc      = src;
    ImmExt     = imm;
    ALUResult  = alu;
    q.push_back(exp_t'{pc: m_pc, instr: rd, cnt: m_ret});
    @(negedge clk);
    imem_ready = 1'b0;
    chk("valid_in_exec", {31'd0, instr_valid}, 32'd1);
    nxt = model_next(m_pc, src, imm, alu);
    @(negedge clk);
    if (nxt[1:0] != 2'b00) begin
      chk("mis_flag", {31'd0, misaligned}, 32'd1);
      chk("mis_bad", bad_addr, nxt);
      chk("mis_pc", PC, m_pc);
      chk("mis_instret", instret, m_ret);
      chk("mis_instr", Instr, NOPI);
      trap_quiet("mis_trap");
    end else begin
      m_pc  = nxt;
      m_ret = m_ret + 32'd1;
      chk("instret_after", instret, m_ret);
      chk("mis_clear", {31'd0, misaligned}, 32'd0);
      chk("ferr_clear", {31'd0, fetch_err}, 32'd0);
    end
  endtask

  initial begin
    logic [1:0]  src;
    logic [31:0] imm, alu;
    int          w;
    bit          ok;

    do_reset();
    // Sequential NOPs with an always-ready memory.
    xact(0, NOPI, 2'b00, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) xact(0, NOPI, 2'b00, 32'd0, 32'd0, 1'b1);
    chk("instret_four", instret, 32'd4);
    // Branches from 0x10.
    xact(0, $urandom, 2'b01, 32'hFFFF_FFF0, 32'd0, 1'b1);
    xact(0, $urandom, 2'b01, 32'h0000_0010, 32'd0, 1'b1);
    xact(0, $urandom, 2'b01, 32'h0000_0020, 32'd0, 1'b1);
    chk("branch_to_30", PC, 32'h30);
    xact(0, $urandom, 2'b01, 32'h0, 32'd0, 1'b1);
    chk("self_loop_pc", PC, 32'h30);
    xact(0, $urandom, 2'b10, 32'd0, 32'h0000_0105, 1'b1);
    chk("jalr_104", PC, 32'h104);
    xact(1, $urandom, 2'b10, 32'd0, 32'hFFFF_FFFD, 1'b1);
    xact(0, $urandom, 2'b11, 32'd0, 32'd0, 1'b1);
    chk("wrap_pc", PC, 32'h0);
    xact(TO - 1, $urandom, 2'b00, 32'd0, 32'd0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      src = 2'($urandom_range(0, 3));
      imm = $urandom & 32'hFFFF_FFFC;
      alu = $urandom & 32'hFFFF_FFFD;
      xact($urandom_range(0, 4), $urandom, src, imm, alu, 1'b0);
    end

    // Misaligned JALR target, then misaligned branch.
    xact(0, $urandom, 2'b10, 32'd0, 32'h0000_0106, 1'b0);
    do_reset();
    xact(0, $urandom, 2'b01, 32'h0000_0002, 32'd0, 1'b0);
    do_reset();

    // Fetch timeout.
    xact(0, NOPI, 2'b00, 32'd0, 32'd0, 1'b0);
    wait_req(ok, w);
    if (ok) begin
      chk("to_addr", imem_addr, m_pc);
      imem_ready = 1'b0;
      repeat (TO) @(negedge clk);
      chk("to_ferr", {31'd0, fetch_err}, 32'd1);
      chk("to_bad", bad_addr, m_pc);
      chk("to_instret", instret, m_ret);
      trap_quiet("to_trap");
    end
    do_reset();

    // Reset during FETCH with a response in flight.
    xact(0, NOPI, 2'b00, 32'd0, 32'd0, 1'b0);
    wait_req(ok, w);
    if (ok) begin
      @(negedge clk);
      #2 reset = 1'b0;
      #1 chk("async_req_drop", {31'd0, imem_req}, 32'd0);
      imem_ready = 1'b1;
      imem_rdata = $urandom;
      @(negedge clk);
      imem_ready = 1'b0;
      reset      = 1'b1;
      m_pc       = RST_PC;
      m_ret      = 32'd0;
      chk("rst_mid_instret", instret, 32'd0);
      chk("rst_mid_pc", PC, RST_PC);
    end
    xact(2, $urandom, 2'b00, 32'd0, 32'd0, 1'b0);
    xact(0, $urandom, 2'b01, 32'h0000_0100, 32'd0, 1'b1);
    chk("final_pc", PC, 32'h104);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
